// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// Stage 0 forms bitwise terms, stages 1..LEVELS run the prefix tree, the last stage forms sum/cout/ovf.
module ks_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ai,
    input  logic [WIDTH-1:0] Bi,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAST   = LEVELS + 1;

    logic                          adv;
    logic [LAST:0]                 vld_q;

    logic [WIDTH-1:0]              b_eff;
    logic                          ci_eff;
    logic [WIDTH-1:0]              p_in;
    logic [WIDTH-1:0]              g_in;

    // g_d/p_d[k] are the next values of g_q/p_q[k]; index 0 is the operand stage.
    logic [LEVELS:0][WIDTH-1:0]    g_d;
    logic [LEVELS:0][WIDTH-1:0]    g_q;
    logic [LEVELS-1:0][WIDTH-1:0]  p_d;
    logic [LEVELS-1:0][WIDTH-1:0]  p_q;
    logic [LEVELS:0][WIDTH-1:0]    h_q;
    logic [LEVELS:0]               ci_q;

    logic [WIDTH-1:0]              g_fin;
    logic [WIDTH-1:0]              c_vec;

    assign out_valid = vld_q[LAST];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !rst;

    assign b_eff  = sub ? ~Bi : Bi;
    assign ci_eff = sub | cin;
    assign p_in   = Ai | b_eff;

    always_comb begin
        g_in    = Ai & b_eff;
        g_in[0] = g_in[0] | (p_in[0] & ci_eff);
    end

    assign g_d[0] = g_in;
    assign p_d[0] = p_in;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int SPAN = 1 << (k - 1);
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_op
                assign g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-SPAN]);
            end else begin : g_pass
                assign g_d[k][i] = g_q[k-1][i];
            end
            // The last level only needs G, so P stops one level early.
            if (k < LEVELS) begin : g_prop
                if (i >= SPAN) begin : g_op
                    assign p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-SPAN];
                end else begin : g_pass
                    assign p_d[k][i] = p_q[k-1][i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[LAST-1:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            g_q  <= g_d;
            p_q  <= p_d;
            h_q  <= {h_q[LEVELS-1:0], Ai ^ b_eff};
            ci_q <= {ci_q[LEVELS-1:0], ci_eff};
        end
    end

    assign g_fin = g_q[LEVELS];
    assign c_vec = {g_fin[WIDTH-2:0], ci_q[LEVELS]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (adv) begin
            sum  <= h_q[LEVELS] ^ c_vec;
            cout <= g_fin[WIDTH-1];
            ovf  <= c_vec[WIDTH-1] ^ g_fin[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Directed and randomized checks for ks_adder_pipe at WIDTH=16.
module tb_ks_adder_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Ai;
    logic [15:0] Bi;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int          n_vec = 0;
    int          n_err = 0;
    logic        last_acc = 1'b0;
    logic        sb_on = 1'b0;
    logic [17:0] sb_q [$];

    ks_adder_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ai        (Ai),
        .Bi        (Bi),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        logic [15:0] be;
        logic        c;
        logic [16:0] r;
        be = sb ? ~b : b;
        c  = sb ? 1'b1 : ci;
        r  = {1'b0, a} + {1'b0, be} + {16'b0, c};
        return {r[15:0], r[16], (a[15] == be[15]) && (r[15] != a[15])};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are judged mid-cycle; the task returns 1ns after the next rising edge.
    task automatic tick();
        logic acc;
        logic del;
        @(negedge clk);
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        last_acc = acc;
        if (sb_on) begin
            if (acc) sb_q.push_back(model(Ai, Bi, cin, sub));
            if (del) begin
                if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
                else check("sb_result", {14'b0, sum, cout, ovf}, {14'b0, sb_q.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sb,
                            input logic [15:0] es, input logic ec, input logic eo);
        int n;
        Ai = a; Bi = b; cin = ci; sub = sb; in_valid = 1'b1;
        tick();
        check({tag, "_acc"}, last_acc, 1);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 6);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
        tick();
    endtask

    initial begin
        int got;
        int nxt;
        int guard;
        int seen;
        int n;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Ai = '0; Bi = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        op_check("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op_check("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op_check("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        op_check("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op_check("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op_check("sub_zero",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        op_check("sub_cin_x", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0);

        // Back-pressure: six back-to-back sets fill the pipe, then the consumer stalls.
        for (int k = 1; k <= 6; k++) begin
            Ai = 16'(k); Bi = 16'(k); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
            check("bp_acc", last_acc, 1);
        end
        check("bp_first_valid", out_valid, 1);
        check("bp_first_sum", sum, 16'h0002);
        out_ready = 1'b0;
        Ai = 16'd7; Bi = 16'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold_acc", last_acc, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_sum", sum, 16'h0002);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        got = 0; nxt = 7; guard = 0;
        while (got < 8 && guard < 40) begin
            if (out_valid) begin
                check("bp_order", sum, 2 * (got + 1));
                got++;
            end
            tick();
            guard++;
            if (guard == 1) check("bp_simul_acc", last_acc, 1);
            if (last_acc) nxt++;
            if (nxt <= 8) begin
                Ai = 16'(nxt); Bi = 16'(nxt); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("bp_count", got, 8);
        in_valid = 1'b0;
        repeat (8) tick();

        // Reset with three operations in flight.
        for (int k = 1; k <= 3; k++) begin
            Ai = 16'(k * 256); Bi = 16'(k); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_release", in_ready, 1);
        seen = 0;
        repeat (12) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_none_emerge", seen, 0);

        // Random operands with random in_valid/out_ready against the reference model.
        sb_q.delete();
        sb_on = 1'b1;
        last_acc = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                Ai  = 16'($urandom);
                Bi  = 16'($urandom);
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check("rand_drain_empty", sb_q.size(), 0);
        sb_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
